// File: rtl/tiny_dnn_seq_if.sv
// Sequencer-to-core-array bus: shared core strobes/addresses plus the result
// stream presented to the collector.
interface tiny_dnn_seq_if #(
    parameter int out_num = 16
);
    localparam int idx_w = (out_num > 1) ? $clog2(out_num) : 1;

    logic             init;
    logic             exec;
    logic             bias;
    logic             dwconv;
    logic             update;
    logic             outr;
    logic [10:0]      ra;
    logic [10:0]      ia;
    logic             out_valid;
    logic             out_ready;
    logic [idx_w-1:0] out_idx;

    modport master (
        output init, exec, bias, dwconv, update, outr, ra, ia,
        output out_valid, out_idx,
        input  out_ready
    );

    modport slave (
        input  init, exec, bias, dwconv, update, outr, ra, ia,
        input  out_valid, out_idx,
        output out_ready
    );
endinterface

// File: rtl/tiny_dnn_seq.sv
// Pass sequencer for a chain of tiny_dnn_core MAC cores: clear, MAC, optional
// bias, pipeline flush, then serial drain of every core's result.
//
// state   | meaning
// IDLE    | waiting for start, configuration latched on start
// INIT    | one cycle of accumulator clear
// EXEC    | len MAC cycles, address counter walks 0..len-1
// BIAS    | one bias-add cycle (only when bias_en was latched)
// FLUSH   | flush cycles with strobes low while the core pipeline empties
// DRAIN   | out_num result beats through the outr shift chain
// DONE    | one-cycle done pulse
module tiny_dnn_seq #(
    parameter int f_size  = 1024,
    parameter int fs_size = 10,
    parameter int out_num = 16,
    parameter int flush   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode_dw,
    input  logic        bias_en,
    input  logic        bank,
    input  logic [10:0] kernel_len,
    input  logic [9:0]  ia_base,
    output logic        busy,
    output logic        done,
    tiny_dnn_seq_if.master core
);
    localparam int idx_w = (out_num > 1) ? $clog2(out_num) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(out_num - 1);
    localparam logic [10:0] flush_ld = 11'((flush > 0) ? flush - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_EXEC, S_BIAS, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      rem_q, rem_d;
    logic [9:0]       c_q, c_d;
    logic [idx_w-1:0] idx_q, idx_d;
    logic             mdw_q, mdw_d, ben_q, ben_d, bnk_q, bnk_d;
    logic [10:0]      len_q, len_d;
    logic [9:0]       iab_q, iab_d;
    logic [10:0]      len_max;
    logic             go_post;

    logic             init_d, exec_d, bias_d, dwconv_d, update_d, valid_d;
    logic             busy_d, done_d;
    logic [10:0]      ra_d, ia_d;
    logic [idx_w-1:0] out_idx_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        c_d     = c_q;
        idx_d   = idx_q;
        mdw_d   = mdw_q;
        ben_d   = ben_q;
        bnk_d   = bnk_q;
        len_d   = len_q;
        iab_d   = iab_q;
        go_post = 1'b0;
        len_max = mode_dw ? 11'(fs_size - 1) : 11'(f_size - 1);

        case (state_q)
            S_IDLE: if (start) begin
                mdw_d   = mode_dw;
                ben_d   = bias_en;
                bnk_d   = bank;
                iab_d   = ia_base;
                len_d   = (kernel_len > len_max) ? len_max : kernel_len;
                state_d = S_INIT;
            end
            S_INIT: begin
                if (len_q != 11'd0) begin
                    state_d = S_EXEC;
                    rem_d   = len_q - 11'd1;
                    c_d     = 10'd0;
                end else if (ben_q) begin
                    state_d = S_BIAS;
                end else begin
                    go_post = 1'b1;
                end
            end
            S_EXEC: begin
                if (rem_q == 11'd0) begin
                    if (ben_q) state_d = S_BIAS;
                    else       go_post = 1'b1;
                end else begin
                    rem_d = rem_q - 11'd1;
                    c_d   = c_q + 10'd1;
                end
            end
            S_BIAS:  go_post = 1'b1;
            S_FLUSH: begin
                if (rem_q == 11'd0) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    rem_d = rem_q - 11'd1;
                end
            end
            S_DRAIN: if (core.out_ready) begin
                if (idx_q == last_idx) state_d = S_DONE;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A zero-depth core pipeline goes straight from the last MAC to the drain.
        if (go_post) begin
            if (flush > 0) begin
                state_d = S_FLUSH;
                rem_d   = flush_ld;
            end else begin
                state_d = S_DRAIN;
                idx_d   = '0;
            end
        end

        init_d    = (state_d == S_INIT);
        exec_d    = (state_d == S_EXEC);
        bias_d    = (state_d == S_BIAS);
        valid_d   = (state_d == S_DRAIN);
        update_d  = valid_d && (idx_d == '0);
        out_idx_d = valid_d ? idx_d : '0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        dwconv_d  = mdw_d && (state_d inside {S_INIT, S_EXEC, S_BIAS, S_FLUSH, S_DRAIN});
        ra_d      = exec_d ? {bnk_d, c_d} : (bias_d ? {bnk_d, 10'd0} : 11'd0);
        ia_d      = (exec_d && mdw_d) ? {bnk_d, iab_d + c_d} : 11'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rem_q          <= '0;
            c_q            <= '0;
            idx_q          <= '0;
            mdw_q          <= 1'b0;
            ben_q          <= 1'b0;
            bnk_q          <= 1'b0;
            len_q          <= '0;
            iab_q          <= '0;
            core.init      <= 1'b0;
            core.exec      <= 1'b0;
            core.bias      <= 1'b0;
            core.dwconv    <= 1'b0;
            core.update    <= 1'b0;
            core.ra        <= '0;
            core.ia        <= '0;
            core.out_valid <= 1'b0;
            core.out_idx   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            c_q            <= c_d;
            idx_q          <= idx_d;
            mdw_q          <= mdw_d;
            ben_q          <= ben_d;
            bnk_q          <= bnk_d;
            len_q          <= len_d;
            iab_q          <= iab_d;
            core.init      <= init_d;
            core.exec      <= exec_d;
            core.bias      <= bias_d;
            core.dwconv    <= dwconv_d;
            core.update    <= update_d;
            core.ra        <= ra_d;
            core.ia        <= ia_d;
            core.out_valid <= valid_d;
            core.out_idx   <= out_idx_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

    // The chain must shift in the same cycle the collector accepts a beat.
    assign core.outr = core.out_valid & core.out_ready;
endmodule

// File: doc/tiny_dnn_seq.md
Name: tiny_dnn_seq

Overview:
- Initiator/sequencer for a chain of `tiny_dnn_core` MAC cores. It drives all of their shared control and address inputs.
- One pass runs: accumulator clear, `kernel_len` multiply-accumulate reads, an optional bias add, a pipeline flush, then a serial drain of every core's result through the `outr`/`sum_in` shift chain.
- It sits between the layer-level controller (`start`/`done`) and the core array. It presents a `valid`/`ready` stream to the result collector, which samples the last core's `sum`.

Parameters:
- `f_size`, 1024: weight-bank depth. Address `f_size-1` is reserved for bias.
- `fs_size`, 10: depthwise weight-buffer depth. Address `fs_size-1` is reserved for bias.
- `out_num`, 16: number of cores in the `outr` chain, i.e. drain beats per pass (≥1).
- `flush`, 3: cycles from the last `exec`/`bias` to final `suml` valid (core pipeline depth).

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: pass request, sampled in IDLE only.
- `mode_dw` input 1: depthwise pass, sampled at start.
- `bias_en` input 1: add bias after MACs, sampled at start.
- `bank` input 1: weight bank (bit 10 of `ra`/`ia`), sampled at start.
- `kernel_len` input 11: number of MAC cycles, sampled at start.
- `ia_base` input 10: depthwise data base address, sampled at start.
- `busy` output 1: high from the cycle after an accepted start through the DONE cycle.
- `done` output 1: one-cycle pulse at end of pass.
- `init` output 1: core accumulator clear.
- `exec` output 1: core MAC enable.
- `bias` output 1: core bias-add enable.
- `dwconv` output 1: core depthwise select.
- `update` output 1: core sum-mux select (`suml`).
- `outr` output 1: core shift-chain enable.
- `ra` output 11: core weight/read address.
- `ia` output 11: core depthwise data address.
- `out_valid` output 1: last core's `sum` holds a result.
- `out_ready` input 1: collector accepts the current result.
- `out_idx` output `$clog2(out_num)`: index of the current result (0 = last core).

Behaviour:
- **Reset.** All outputs are 0 and the state is IDLE. A reset mid-pass aborts immediately: no `done`, and partial core state is discarded by the next INIT.
- **States:** IDLE → INIT → EXEC → BIAS → FLUSH → DRAIN → DONE → IDLE. All outputs are registered.
- **IDLE.** `start=1` latches `mode_dw`, `bias_en`, `bank`, `kernel_len`, `ia_base`. `start` is ignored in every other state.
- **Effective length.** `len = kernel_len` clamped to `f_size-1` (normal) or `fs_size-1` (`mode_dw`).
- **INIT.** Exactly 1 cycle with `init=1`.
- **EXEC.** `len` consecutive cycles, `exec=1`, counter `c` = 0..len-1.
  - `ra = {bank, c}`.
  - `ia = {bank, (ia_base + c) mod 1024}` when depthwise, else 0.
  - `len=0`: EXEC is skipped (0 cycles).
- **BIAS.** 1 cycle with `bias=1` and `ra = {bank, 10'd0}` (the core substitutes the bias address), only if `bias_en`; otherwise skipped.
- **`dwconv`.** Equals the latched `mode_dw` from INIT through DRAIN; 0 otherwise.
- **FLUSH.** `flush` cycles with all core strobes low, so the last accumulation lands before the drain.
- **Required timing.** `init` in cycle t, first `exec` at t+1, last `exec`/`bias` at cycle e, first DRAIN cycle = e+1+`flush`.
- **DRAIN.** `out_num` beats; a beat transfers when `out_valid & out_ready`. `out_valid=1` throughout DRAIN.
  - Beat 0: `update=1`, `outr=out_ready`. The transfer loads each core's `sumt` from its upstream neighbour's `suml`. `update` stays 1 while beat 0 is stalled.
  - Beats 1..`out_num-1`: `update=0`, `outr=out_ready`.
  - While stalled, `outr=0`, so the chain holds and `sum` is stable.
  - `out_idx` increments per transfer, 0..`out_num-1`.
  - `out_num=1`: only beat 0.
- **DONE.** 1 cycle with `done=1` and `busy=1`, then IDLE. A `start` in the DONE cycle is ignored; `start` is accepted from the next cycle.
- **Strobe exclusivity.** `init`, `exec` and `bias` are mutually exclusive and never high with `outr`. `write`/`bwrite`/`dwrite` are not driven by this block.

Test Plan:
- **Normal pass.** `kernel_len=4`, `bias_en=0`, `bank=1`, `out_num=4`, `out_ready=1`.
  - `init` 1 cycle, then `exec` 4 cycles with `ra`=0x400..0x403.
  - `out_valid` 3 cycles after the last `exec`, for 4 cycles, with `update` on the first only.
  - `done` the next cycle. A core model with all weights 1.0 and d=2.0 yields 8.0 ×4.
- **Depthwise with bias.** `mode_dw=1`, `kernel_len=20`, `ia_base=1022`, `bias_en=1`.
  - `len` clamped to 9; `ia` = 1022, 1023, 0..6 (`bank=0`); `dwconv=1` throughout.
  - 1 `bias` cycle follows the last `exec`.
- **Backpressure.** `out_ready` low for 5 cycles at beat 0 and 2 cycles at beat 2.
  - `update` held and `outr=0` while stalled; `out_idx` frozen.
  - Collected sequence identical to the no-stall run.
- **Zero length.** `kernel_len=0`, `bias_en=1`.
  - INIT, BIAS, FLUSH, DRAIN: exactly 1 `init` pulse, 1 `bias` cycle and 0 `exec` cycles; the result equals the bias.
- **Start while busy / back-to-back.** `start` pulsed during EXEC and during DONE → ignored. `start` the cycle after DONE → new pass begins with `init` the following cycle.
- **Reset mid-EXEC.**
  - `reset` at `c=2` → the next cycle has all outputs 0, IDLE, no `done`.
  - A subsequent pass produces correct sums; its INIT clears the residue.
